// File: rtl/sub_bytes.sv
// AES forward SubBytes stage: sixteen independent S-box lookups on a 128-bit
// state, with the substituted state captured in a register every cycle.
module sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] data,
    output logic [127:0] s_data_out
);

    // Forward S-box, entry 0x00 in the most significant byte, 0xff in the least.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry v sits at bit offset 8*(255-v), and 255-v is simply ~v.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    logic [127:0] s_data_d;
    logic [127:0] s_data_q;

    always_comb begin
        s_data_d = '0;
        for (int i = 0; i < 16; i++) begin
            s_data_d[8*i +: 8] = sbox(data[8*i +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_data_q <= '0;
        end else begin
            s_data_q <= s_data_d;
        end
    end

    assign s_data_out = s_data_q;

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes: an arithmetic GF(2^8) model is checked
// against the DUT on every cycle, plus literal expectations from the AES tables.
module tb_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic [127:0] data;
    logic [127:0] s_data_out;

    sub_bytes dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .s_data_out (s_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] VEC_IN  = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] VEC_OUT = 128'ha761ca9b97be8b45d8ad1a611fc97369;

    // ---------------- behavioural model: inverse in GF(2^8) + affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        // b^254 is the multiplicative inverse, and maps 0 to 0.
        for (int k = 0; k < 254; k++) inv = gmul(inv, b);
        if (b == 8'h00) inv = 8'h00;
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = model_sbox(d[8*i +: 8]);
        return r;
    endfunction

    // ---------------- model register, advanced on the same edge as the DUT
    logic [127:0] exp_q;
    logic         exp_valid;
    initial exp_valid = 1'b0;

    always @(posedge clk) begin
        exp_q     <= rst_n ? model_state(data) : 128'h0;
        exp_valid <= 1'b1;
    end

    // ---------------- literal expectations posted by the stimulus process
    logic [127:0] lit_exp;
    string        lit_name;
    int           lit_seq;
    initial lit_seq = 0;

    int n_cmp;
    int n_bad;

    initial begin : compare
        int lit_done;
        logic [7:0] pin_in  [6];
        logic [7:0] pin_out [6];
        logic [7:0] got;
        n_cmp = 0;
        n_bad = 0;
        lit_done = 0;
        pin_in  = '{8'h00, 8'h01, 8'h53, 8'h89, 8'hd8, 8'hff};
        pin_out = '{8'h63, 8'h7c, 8'hed, 8'ha7, 8'h61, 8'h16};
        for (int k = 0; k < 6; k++) begin
            got = model_sbox(pin_in[k]);
            n_cmp++;
            if (got !== pin_out[k]) begin
                n_bad++;
                $display("FAIL model_pin in=%h got %h want %h", pin_in[k], got, pin_out[k]);
            end
        end
        n_cmp++;
        if (model_state(VEC_IN) !== VEC_OUT) begin
            n_bad++;
            $display("FAIL model_vector got %h want %h", model_state(VEC_IN), VEC_OUT);
        end
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                n_cmp++;
                if (s_data_out !== exp_q) begin
                    n_bad++;
                    $display("FAIL model_cycle t=%0t got %h want %h", $time, s_data_out, exp_q);
                end
            end
            if (lit_seq != lit_done) begin
                lit_done = lit_seq;
                n_cmp++;
                if (s_data_out !== lit_exp) begin
                    n_bad++;
                    $display("FAIL %s got %h want %h", lit_name, s_data_out, lit_exp);
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic apply(input logic rst, input logic [127:0] d);
        rst_n = rst;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [127:0] v);
        lit_name = name;
        lit_exp  = v;
        lit_seq  = lit_seq + 1;
        $display("check %s expecting %h", name, v);
    endtask

    initial begin : stim
        logic [127:0] v;
        rst_n = 1'b0;
        data  = VEC_IN;

        apply(1'b0, VEC_IN);  expect_lit("reset_edge1", 128'h0);
        apply(1'b0, VEC_IN);  expect_lit("reset_edge2", 128'h0);
        apply(1'b1, VEC_IN);  expect_lit("known_vector", VEC_OUT);
        apply(1'b1, VEC_IN);  expect_lit("known_vector_hold", VEC_OUT);
        apply(1'b1, 128'h0);  expect_lit("all_zero", {16{8'h63}});
        apply(1'b1, '1);      expect_lit("all_ones", {16{8'h16}});
        apply(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        expect_lit("lane_order", 128'h637c777bf26b6fc53001672bfed7ab76);

        apply(1'b1, 128'h0);  expect_lit("b2b_first", {16{8'h63}});
        apply(1'b1, VEC_IN);  expect_lit("b2b_second", VEC_OUT);
        apply(1'b0, VEC_IN);  expect_lit("midstream_reset", 128'h0);
        apply(1'b1, VEC_IN);  expect_lit("after_reset", VEC_OUT);

        // data glitching between edges must not reach the output
        rst_n = 1'b1;
        data  = '1;
        #2;
        data  = 128'h0;
        @(posedge clk);
        #1;
        expect_lit("mid_cycle_change", {16{8'h63}});

        for (int b = 0; b < 256; b++) begin
            apply(1'b1, {16{8'(b)}});
        end
        // Distinct byte per lane to catch lane swaps across the whole table.
        for (int b = 0; b < 256; b += 16) begin
            for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(b + i * 17);
            apply(1'b1, v);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
